// File: rtl/output_capture.sv
// output_capture: capture sink for the CPU output stream.
//
// Every accepted CPU output word is stored in a capture RAM at the next free
// index and compared, one cycle later, against a host-preloaded expected RAM.
// The block reports word count, mismatch count, the first failing index and
// end-of-run status, and offers a registered readback port into the capture RAM.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   out_write     CPU output strobe, one word per cycle
//   out_data      CPU output word
//   exp_write     host write strobe into the expected RAM
//   addr_in       host address for expected-RAM writes and capture readback
//   data_in       host expected-value data
//   exp_len       number of output words the run should produce
//   rd_data       capture RAM word at addr_in, one cycle latency
//   count         words accepted since reset
//   mismatches    compare failures, saturating
//   first_bad     index of the first mismatch (valid when mismatches != 0)
//   done          run finished (possibly with extra words)
//   pass          finished cleanly: no mismatches, no extra words, no overflow
//   overflow      sticky: a word arrived with the capture RAM full
module output_capture #(
    parameter int unsigned DEPTH_LOG2 = 13,
    parameter int unsigned WIDTH      = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  out_write,
    input  logic [WIDTH-1:0]      out_data,
    input  logic                  exp_write,
    input  logic [DEPTH_LOG2-1:0] addr_in,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [DEPTH_LOG2:0]   exp_len,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   mismatches,
    output logic [DEPTH_LOG2-1:0] first_bad,
    output logic                  done,
    output logic                  pass,
    output logic                  overflow
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StExtra
    } state_e;

    logic [WIDTH-1:0] cap_mem [Depth];
    logic [WIDTH-1:0] exp_mem [Depth];

    state_e                state_q, state_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DEPTH_LOG2:0]   mism_q, mism_d;
    logic [DEPTH_LOG2-1:0] first_bad_q, first_bad_d;
    logic                  overflow_q, overflow_d;
    logic [WIDTH-1:0]      rd_data_q;

    // Compare pipeline stage: captured word, its index and the expected word.
    logic                  vld_q, vld_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic [WIDTH-1:0]      exp_rd_q;

    logic                  accept;
    logic                  cmp_en;
    logic                  bad;
    logic [DEPTH_LOG2-1:0] wr_idx;

    // The MSB of count set means all Depth entries are used.
    assign accept = out_write && !count_q[DEPTH_LOG2];
    assign wr_idx = count_q[DEPTH_LOG2-1:0];
    // Words past the expected length are captured but not compared.
    assign cmp_en = accept && (count_q < exp_len);
    assign bad    = vld_q && (data_q != exp_rd_q);

    // Capture RAM and readback; the read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            cap_mem[wr_idx] <= out_data;
        end
        rd_data_q <= cap_mem[addr_in];
    end

    // Expected RAM; a same-cycle host write is not seen by the compare read.
    always_ff @(posedge clk) begin
        if (exp_write) begin
            exp_mem[addr_in] <= data_in;
        end
        exp_rd_q <= exp_mem[wr_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            mism_q      <= '0;
            first_bad_q <= '0;
            overflow_q  <= 1'b0;
            vld_q       <= 1'b0;
            idx_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mism_q      <= mism_d;
            first_bad_q <= first_bad_d;
            overflow_q  <= overflow_d;
            vld_q       <= vld_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        mism_d      = mism_q;
        first_bad_d = first_bad_q;
        vld_d       = cmp_en;
        idx_d       = wr_idx;
        data_d      = out_data;

        if (accept) begin
            count_d = count_q + 1'b1;
        end
        if (out_write && count_q[DEPTH_LOG2]) begin
            overflow_d = 1'b1;
        end

        if (bad) begin
            if (mism_q != '1) begin
                mism_d = mism_q + 1'b1;
            end
            if (mism_q == '0) begin
                first_bad_d = idx_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (exp_len == '0) begin
                    state_d = StDone;
                end else if (out_write) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A word beyond the expected length ends the run as EXTRA even
                // while the last compare is still in flight.
                if (out_write && (count_q >= exp_len)) begin
                    state_d = StExtra;
                end else if ((count_q >= exp_len) && !vld_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_write) begin
                    state_d = StExtra;
                end
            end
            StExtra: begin
                state_d = StExtra;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rd_data    = rd_data_q;
    assign count      = count_q;
    assign mismatches = mism_q;
    assign first_bad  = first_bad_q;
    assign overflow   = overflow_q;
    assign done       = (state_q == StDone) || (state_q == StExtra);
    assign pass       = done && (mism_q == '0) && (state_q != StExtra) && !overflow_q;

endmodule

// File: tb/tb_output_capture.sv
// Testbench for output_capture: directed scenarios plus randomized runs, with
// expected values pushed into a scoreboard queue and checked by a monitor.
module tb_output_capture;

    localparam int DL    = 13;
    localparam int W     = 12;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          out_write = 1'b0;
    logic [W-1:0]  out_data = '0;
    logic          exp_write = 1'b0;
    logic [DL-1:0] addr_in = '0;
    logic [W-1:0]  data_in = '0;
    logic [DL:0]   exp_len = '0;
    logic [W-1:0]  rd_data;
    logic [DL:0]   count;
    logic [DL:0]   mismatches;
    logic [DL-1:0] first_bad;
    logic          done;
    logic          pass;
    logic          overflow;

    output_capture #(
        .DEPTH_LOG2(DL),
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .out_write (out_write),
        .out_data  (out_data),
        .exp_write (exp_write),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .exp_len   (exp_len),
        .rd_data   (rd_data),
        .count     (count),
        .mismatches(mismatches),
        .first_bad (first_bad),
        .done      (done),
        .pass      (pass),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard entry: which output, the cycle it is due, the required value.
    typedef struct {
        int kind;
        int due;
        int val;
    } sb_t;
    sb_t sbq[$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic string kname(int k);
        case (k)
            0: return "rd_data";
            1: return "count";
            2: return "mismatches";
            3: return "first_bad";
            4: return "done";
            5: return "pass";
            default: return "overflow";
        endcase
    endfunction

    function automatic int actual(int k);
        case (k)
            0: return int'(rd_data);
            1: return int'(count);
            2: return int'(mismatches);
            3: return int'(first_bad);
            4: return int'(done);
            5: return int'(pass);
            default: return int'(overflow);
        endcase
    endfunction

    always @(negedge clk) begin
        sb_t keep[$];
        keep = {};
        foreach (sbq[i]) begin
            if (sbq[i].due == cyc) begin
                n_vec++;
                if (actual(sbq[i].kind) != sbq[i].val) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                             kname(sbq[i].kind), cyc, actual(sbq[i].kind), sbq[i].val);
                end
            end else if (sbq[i].due < cyc) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s stale entry due=%0d cyc=%0d", kname(sbq[i].kind),
                         sbq[i].due, cyc);
            end else begin
                keep.push_back(sbq[i]);
            end
        end
        sbq = keep;
    end

    // Reference model: the list of words offered since reset and, per word,
    // the expected value the RAM held when that word arrived.
    logic [W-1:0] cap_m [DEPTH];
    logic [W-1:0] exp_m [DEPTH];
    logic [W-1:0] words[$];
    logic [W-1:0] expv[$];
    int           len_m = 0;

    function automatic int m_count();
        return (words.size() > DEPTH) ? DEPTH : words.size();
    endfunction

    function automatic int m_mism();
        int c = 0;
        for (int i = 0; i < m_count(); i++) begin
            if (i < len_m && words[i] != expv[i]) c++;
        end
        return c;
    endfunction

    function automatic int m_first();
        for (int i = 0; i < m_count(); i++) begin
            if (i < len_m && words[i] != expv[i]) return i;
        end
        return 0;
    endfunction

    function automatic int m_done();
        return (len_m == 0 || m_count() >= len_m) ? 1 : 0;
    endfunction

    function automatic int m_pass();
        int extra = (words.size() > len_m) ? 1 : 0;
        int ovf   = (words.size() > DEPTH) ? 1 : 0;
        return (m_done() == 1 && m_mism() == 0 && extra == 0 && ovf == 0) ? 1 : 0;
    endfunction

    task automatic push(input int kind, input int due, input int val);
        sb_t e;
        e.kind = kind;
        e.due  = due;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all();
        push(1, cyc, m_count());
        push(2, cyc, m_mism());
        push(4, cyc, m_done());
        push(5, cyc, m_pass());
        push(6, cyc, (words.size() > DEPTH) ? 1 : 0);
        if (m_mism() != 0) push(3, cyc, m_first());
    endtask

    task automatic do_reset(input int len);
        exp_len = len[DL:0];
        len_m   = len;
        rst     = 1'b1;
        step(2);
        rst = 1'b0;
        words.delete();
        expv.delete();
    endtask

    task automatic wr(input logic [W-1:0] d);
        int n = words.size();
        out_write = 1'b1;
        out_data  = d;
        if (n < DEPTH) begin
            cap_m[n] = d;
            expv.push_back(exp_m[n]);
        end else begin
            expv.push_back('0);
        end
        words.push_back(d);
        step(1);
        out_write = 1'b0;
    endtask

    task automatic exp_ld(input int a, input logic [W-1:0] d);
        exp_write = 1'b1;
        addr_in   = a[DL-1:0];
        data_in   = d;
        exp_m[a]  = d;
        step(1);
        exp_write = 1'b0;
    endtask

    task automatic rb(input int a);
        addr_in = a[DL-1:0];
        push(0, cyc + 1, int'(cap_m[a]));
        step(1);
    endtask

    initial begin
        // Clean run of four matching words, with done latency and readback.
        for (int i = 0; i < 4; i++) exp_ld(i, W'(i + 1));
        do_reset(4);
        push(1, cyc, 0);
        push(2, cyc, 0);
        push(6, cyc, 0);
        step(1);
        push(4, cyc, 0);
        for (int i = 0; i < 4; i++) wr(W'(i + 1));
        push(1, cyc, 4);
        push(4, cyc, 0);
        push(4, cyc + 1, 0);
        push(4, cyc + 2, 1);
        step(3);
        check_all();
        rb(2);

        // Third word wrong.
        do_reset(4);
        step(1);
        wr(12'h001);
        wr(12'h002);
        wr(12'hFFF);
        wr(12'h004);
        step(3);
        check_all();

        // One word more than expected.
        do_reset(2);
        step(1);
        wr(12'h001);
        wr(12'h002);
        wr(12'h0AB);
        step(3);
        check_all();
        rb(2);

        // Empty run completes immediately.
        do_reset(0);
        step(1);
        push(4, cyc, 1);
        push(5, cyc, 1);
        step(2);
        check_all();

        // Reset mid-run, then replay.
        do_reset(4);
        step(1);
        wr(12'h001);
        wr(12'h002);
        do_reset(4);
        push(1, cyc, 0);
        step(1);
        for (int i = 0; i < 4; i++) wr(W'(i + 1));
        step(3);
        check_all();

        // Host rewrite of exp[0] in the same cycle as its compare.
        do_reset(1);
        step(1);
        out_write = 1'b1;
        out_data  = 12'h001;
        exp_write = 1'b1;
        addr_in   = '0;
        data_in   = 12'h777;
        cap_m[0]  = 12'h001;
        expv.push_back(exp_m[0]);
        words.push_back(12'h001);
        exp_m[0] = 12'h777;
        step(1);
        out_write = 1'b0;
        exp_write = 1'b0;
        step(3);
        check_all();
        // The rewritten value is what the next run compares against.
        do_reset(1);
        step(1);
        wr(12'h001);
        step(3);
        check_all();

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            int len = $urandom_range(1, 24);
            int lo  = (len > 1) ? len - 1 : 1;
            int n   = $urandom_range(lo, len + 2);
            for (int i = 0; i < len + 3; i++) exp_ld(i, W'($urandom_range(0, 3)));
            do_reset(len);
            step(1);
            for (int k = 0; k < n; k++) begin
                logic [W-1:0] d;
                if ($urandom_range(0, 9) < 7) d = exp_m[k];
                else d = W'($urandom_range(0, 3));
                wr(d);
                if ($urandom_range(0, 2) == 0) step(1);
            end
            step(3);
            check_all();
            rb($urandom_range(0, n - 1));
            rb($urandom_range(0, n - 1));
        end

        // Fill the capture RAM completely, then one word more.
        for (int i = 0; i < DEPTH; i++) exp_ld(i, W'(i));
        do_reset(DEPTH);
        step(1);
        for (int i = 0; i < DEPTH; i++) wr(W'(i));
        push(6, cyc, 0);
        wr(12'hABC);
        step(3);
        check_all();
        rb(0);
        rb(DEPTH - 1);

        step(3);
        for (int i = 0; i < 10 && sbq.size() > 0; i++) step(1);
        if (sbq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/output_capture.md
Name: output_capture

Overview:
- Capture sink for the CPU's output stream.
- Each CPU output strobe stores a 12-bit word in a capture RAM and compares it in a pipeline against an expected-value RAM that the host preloads.
- The block tracks count, mismatches and end-of-run status, and gives the host a registered readback port into the captured data.
- It is the output-side counterpart of the host-loaded input stream memories and sits between the CPU output port and the host/test harness.

Parameters:
- DEPTH_LOG2, 13, address width; both RAMs hold 2^DEPTH_LOG2 words.
- WIDTH, 12, data word width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- out_write  input  1  CPU output strobe; one word per cycle when high
- out_data  input  WIDTH  CPU output word
- exp_write  input  1  host write strobe into the expected RAM
- addr_in  input  DEPTH_LOG2  host address for both the exp_write and readback ports
- data_in  input  WIDTH  host expected-value data
- exp_len  input  DEPTH_LOG2+1  expected output count; sampled while in IDLE and RUN
- rd_data  output reg  WIDTH  capture RAM word at addr_in, registered
- count  output reg  DEPTH_LOG2+1  words accepted since reset
- mismatches  output reg  DEPTH_LOG2+1  compare failures, saturating
- first_bad  output reg  DEPTH_LOG2  index of the first mismatch; valid when mismatches != 0
- done  output  1  state == DONE or EXTRA
- pass  output  1  done && mismatches == 0 && state != EXTRA
- overflow  output reg  1  write attempted with the capture RAM full

Behaviour:
Clock and reset:
- Single clock domain.
- Reset is synchronous and active-high on rst.
- rst zeroes count, mismatches, first_bad, overflow, the compare pipeline and state (to IDLE). rd_data is undefined until its first clocked read.
- RAM contents are not cleared by reset.
- Reset mid-run abandons the run. An out_write in the reset cycle is ignored.

Capture:
- On out_write, if count < 2^DEPTH_LOG2: cap[count[DEPTH_LOG2-1:0]] <= out_data, and count increments.
- Otherwise: the word is dropped, count holds, and overflow is set sticky.

Compare pipeline (1 stage):
- Accept cycle: exp[index] is read synchronously; the index and out_data are registered with a valid bit.
- Next cycle, if valid and the registered data != the read expected value:
  - mismatches increments, saturating at all-ones.
  - If mismatches was 0, first_bad <= the registered index.
- Statistics therefore lag count by 1 cycle.

Expected RAM:
- Host exp_write at the same address as a same-cycle compare read: the compare sees the old value (read-before-write).

Readback:
- rd_data <= cap[addr_in] every cycle; 1-cycle latency.
- Same-address out_write in the same cycle returns the old data.

State machine (state register):
- IDLE: entered on reset.
  - If exp_len == 0 -> DONE.
  - If an out_write occurs -> RUN.
- RUN: when count == exp_len and the compare pipeline is empty -> DONE. done therefore rises 2 cycles after the final accept.
- DONE: a further out_write -> EXTRA. The word is still captured, compared only if index < exp_len, and counted.
- EXTRA: terminal until rst; writes are still captured.
- Lowering exp_len below count while in RUN moves to DONE on the next drained cycle.

Overflow:
- Does not change state.
- pass additionally requires overflow == 0.

Test Plan:
- Host loads exp[0..3] = 0x001, 0x002, 0x003, 0x004 with exp_len = 4; CPU writes the same values on consecutive cycles -> count = 4, mismatches = 0, done rises 2 cycles after the 4th write, pass = 1; readback of addr 2 gives 0x003 one cycle after addr_in = 2.
- Same setup but the 3rd word is 0xFFF -> mismatches = 1, first_bad = 2, done = 1, pass = 0.
- exp_len = 2; CPU writes 3 words -> state EXTRA, done = 1, pass = 0, count = 3, cap[2] holds the 3rd word.
- Reset with exp_len = 0 -> done = 1 and pass = 1 the cycle after rst falls, with no writes.
- Fill all 8192 entries, then one more write -> count = 8192, overflow = 1, cap[0] unchanged, pass = 0.
- Assert rst after 2 of 4 writes, then replay all 4 -> count restarts from 0, final count = 4, mismatches = 0, pass = 1; exp_write to addr 0 concurrent with a compare of index 0 -> the compare uses the old value.
